// File: rtl/v_counter.sv
// Vertical timing stage for 640x480 VGA: line counter, vertical-region FSM, registered syncs and video_on.
// Optional V_COUNTER_FRAME_CNT_EN adds an 8-bit frame counter; otherwise frame_count is tied to 0.
module v_counter #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] h_count,
    input  logic       trig_v,
    output logic [9:0] v_count,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_tick,
    output logic [7:0] frame_count,
    output logic [1:0] v_state
);

    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FP_START = 10'(V_VISIBLE);
    localparam logic [9:0] V_SY_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_BP_START = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);

    typedef enum logic [1:0] {
        VIS  = 2'd0,
        FP   = 2'd1,
        SYNC = 2'd2,
        BP   = 2'd3
    } v_state_t;

    v_state_t   state, state_next;
    logic [9:0] v_next;
    logic       wrap;

    always_comb begin
        v_next = v_count;
        wrap   = 1'b0;
        if (trig_v) begin
            if (v_count == V_LAST) begin
                v_next = '0;
                wrap   = 1'b1;
            end else begin
                v_next = v_count + 10'd1;
            end
        end
    end

    // The region follows the line the counter is about to enter, so it changes on the same edge.
    always_comb begin
        state_next = state;
        case (state)
            VIS:     if (v_next == V_FP_START) state_next = FP;
            FP:      if (v_next == V_SY_START) state_next = SYNC;
            SYNC:    if (v_next == V_BP_START) state_next = BP;
            BP:      if (v_next == 10'd0)      state_next = VIS;
            default: state_next = VIS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_count    <= '0;
            state      <= VIS;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            video_on   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            v_count    <= v_next;
            state      <= state_next;
            vsync      <= (state_next != SYNC);
            // Out-of-range h_count falls outside both windows and therefore reads as blanking.
            hsync      <= !((h_count >= HS_START) && (h_count <= HS_END));
            video_on   <= (h_count < H_VIS_END) && (state_next == VIS);
            frame_tick <= wrap;
        end
    end

`ifdef V_COUNTER_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_count <= '0;
        end else if (wrap) begin
            frame_count <= frame_count + 8'd1;
        end
    end
`else
    assign frame_count = '0;
`endif

    assign v_state = state;

endmodule

// File: tb/tb_v_counter.sv
// Directed bench for v_counter: a driver pushes expected outputs per edge, a monitor pops and compares.
// Lines are mostly 3 clocks long; lines 10, 490, 491 and 500 run the full 799-clock sweep.
module tb_v_counter;

    logic       clk;
    logic       rst_n;
    logic [9:0] h_count;
    logic       trig_v;
    logic [9:0] v_count;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       frame_tick;
    logic [7:0] frame_count;
    logic [1:0] v_state;

    v_counter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .h_count     (h_count),
        .trig_v      (trig_v),
        .v_count     (v_count),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .frame_tick  (frame_tick),
        .frame_count (frame_count),
        .v_state     (v_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       tick;
        logic [7:0] fc;
        logic [1:0] st;
        logic       cnt;
    } exp_t;

    exp_t exp_q[$];

    int   n_vec = 0;
    int   n_err = 0;
    int   m_v   = 0;
    logic [7:0] m_fc = '0;
    logic cnt_en = 1'b0;

    int hs_low_cnt  = 0;
    int vo_cnt      = 0;
    int vs_run      = 0;
    int vs_run_last = 0;
    int tick_total  = 0;
    int pop_cyc     = 0;
    int last_tick   = -1;
    int last_gap    = 0;

    function automatic logic [1:0] region(input int v);
        if (v < 480) return 2'd0;
        if (v < 490) return 2'd1;
        if (v < 492) return 2'd2;
        return 2'd3;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Driver: apply one input vector and queue the outputs it must produce after the next edge.
    task automatic step(input logic r, input logic t, input logic [9:0] h);
        exp_t e;
        logic tick;
        @(negedge clk);
        rst_n   = r;
        trig_v  = t;
        h_count = h;
        if (!r) begin
            m_v  = 0;
            m_fc = '0;
            e    = '{v: 10'd0, hs: 1'b1, vs: 1'b1, vo: 1'b0, tick: 1'b0,
                     fc: 8'd0, st: 2'd0, cnt: cnt_en};
        end else begin
            tick = t && (m_v == 524);
            if (t) m_v = (m_v == 524) ? 0 : m_v + 1;
`ifdef V_COUNTER_FRAME_CNT_EN
            if (tick) m_fc = m_fc + 8'd1;
`endif
            e.v    = 10'(m_v);
            e.hs   = !((h >= 10'd656) && (h <= 10'd751));
            e.vs   = !((m_v == 490) || (m_v == 491));
            e.vo   = (h < 10'd640) && (m_v < 480);
            e.tick = tick;
            e.fc   = m_fc;
            e.st   = region(m_v);
            e.cnt  = cnt_en;
        end
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic run_line(input int len);
        step(1'b1, 1'b1, 10'd0);
        for (int h = 1; h < len; h++) step(1'b1, 1'b0, 10'(h));
    endtask

    task automatic drain();
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expected entries never compared, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: one queued expectation per clock edge after the driver has issued it.
    always @(posedge clk) begin
        exp_t e;
        exp_t a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{v: v_count, hs: hsync, vs: vsync, vo: video_on, tick: frame_tick,
                  fc: frame_count, st: v_state, cnt: e.cnt};
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL vec@%0d: got v=%0d hs=%b vs=%b vo=%b tick=%b fc=%0d st=%0d, expected v=%0d hs=%b vs=%b vo=%b tick=%b fc=%0d st=%0d",
                         pop_cyc, a.v, a.hs, a.vs, a.vo, a.tick, a.fc, a.st,
                         e.v, e.hs, e.vs, e.vo, e.tick, e.fc, e.st);
            end
            if (e.cnt) begin
                if (!hsync) hs_low_cnt++;
                if (video_on) vo_cnt++;
            end
            if (!vsync) vs_run++;
            else if (vs_run > 0) begin
                vs_run_last = vs_run;
                vs_run      = 0;
            end
            if (frame_tick) begin
                tick_total++;
                if (last_tick >= 0) last_gap = pop_cyc - last_tick;
                last_tick = pop_cyc;
            end
            pop_cyc++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] h_tab [9];
        int wraps;
        int nxt;
        int len;
        h_tab = '{10'd639, 10'd640, 10'd655, 10'd656, 10'd751, 10'd752, 10'd798, 10'd900, 10'd0};

        rst_n   = 1'b0;
        trig_v  = 1'b0;
        h_count = '0;

        // Reset with trig_v high, including the last reset edge: no line may advance.
        step(1'b0, 1'b1, 10'd700);
        step(1'b0, 1'b1, 10'd0);
        step(1'b1, 1'b0, 10'd5);
        drain();
        check("rst_release_v", v_count, 0);

        // Two complete frames from line 0.
        wraps = 0;
        while (wraps < 2) begin
            nxt = (m_v == 524) ? 0 : m_v + 1;
            len = (nxt == 10 || nxt == 490 || nxt == 491 || nxt == 500) ? 799 : 3;
            if (len == 799) begin
                hs_low_cnt = 0;
                vo_cnt     = 0;
                cnt_en     = 1'b1;
            end
            run_line(len);
            if (len == 799) begin
                cnt_en = 1'b0;
                drain();
                check($sformatf("hsync_low_line%0d", nxt), hs_low_cnt, 96);
                check($sformatf("video_on_line%0d", nxt), vo_cnt, (nxt < 480) ? 640 : 0);
            end
            if (nxt == 0) wraps++;
        end
        drain();
        check("frame_tick_total", tick_total, 2);
        check("frame_period", last_gap, 521 * 3 + 4 * 799);
        check("vsync_low_run", vs_run_last, 1598);

        // Reset in the middle of a frame at line 300.
        while (m_v != 300) run_line(3);
        step(1'b0, 1'b0, 10'd20);
        drain();
        check("midreset_v", v_count, 0);
        step(1'b1, 1'b0, 10'd0);

        // hsync/video_on window boundaries and an out-of-range h_count on line 1.
        step(1'b1, 1'b1, 10'd0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, h_tab[i]);

        // trig_v held for three cycles advances three lines.
        step(1'b1, 1'b1, 10'd0);
        step(1'b1, 1'b1, 10'd1);
        step(1'b1, 1'b1, 10'd2);
        step(1'b1, 1'b0, 10'd3);
        drain();
        check("trig_hold_v", v_count, 4);
`ifndef V_COUNTER_FRAME_CNT_EN
        check("frame_count_tied", frame_count, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
